// File: rtl/call_return_unit.sv
// Hardware call/return sequencer driving an external toggle-strobed return-address stack.
// Build option: define STACK_TRAP_EN to redirect an erroneous call/ret to TRAP_VEC through the ERR state.
module call_return_unit #(
    parameter int            DEPTH    = 16,
    parameter int            DW       = 16,
    parameter logic [DW-1:0] TRAP_VEC = 16'hFFF0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          call,
    input  logic          ret,
    input  logic [DW-1:0] pc_in,
    input  logic [DW-1:0] target,
    output logic [DW-1:0] stk_din,
    input  logic [DW-1:0] stk_dout,
    output logic          stk_en,
    output logic          stk_rwb,
    output logic [DW-1:0] pc_out,
    output logic          pc_load,
    output logic          busy,
    output logic [4:0]    depth,
    output logic          ovf,
    output logic          unf,
    input  logic          clr_err,
    output logic [2:0]    state_dbg
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PUSH = 3'd1;
    localparam logic [2:0] LOAD = 3'd2;
    localparam logic [2:0] POP  = 3'd3;
    localparam logic [2:0] CAPT = 3'd4;
    localparam logic [2:0] ERR  = 3'd5;

    localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);

    // Stack handshake: stk_en is a toggle strobe with no ready. Each change of
    // stk_en is exactly one operation; stk_rwb/stk_din change on that same edge
    // and hold until the next change. Pop data must be on stk_dout within one cycle.

    logic [2:0] state;
    logic [2:0] next_state;
    logic       do_call;
    logic       do_ret;
    logic       ovf_hit;
    logic       unf_hit;

    always_comb begin
        do_call = 1'b0;
        do_ret  = 1'b0;
        ovf_hit = 1'b0;
        unf_hit = 1'b0;
        if (state == IDLE) begin
            // call has priority; a simultaneous ret is simply dropped
            if (call) begin
                do_call = (depth != DEPTH_MAX);
                ovf_hit = (depth == DEPTH_MAX);
            end else if (ret) begin
                do_ret  = (depth != 5'd0);
                unf_hit = (depth == 5'd0);
            end
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: begin
                if (do_call)
                    next_state = PUSH;
                else if (do_ret)
                    next_state = POP;
`ifdef STACK_TRAP_EN
                else if (ovf_hit || unf_hit)
                    next_state = ERR;
`endif
                else
                    next_state = IDLE;
            end
            PUSH:    next_state = LOAD;
            LOAD:    next_state = IDLE;
            POP:     next_state = CAPT;
            CAPT:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            depth   <= 5'd0;
            pc_out  <= '0;
            pc_load <= 1'b0;
            stk_din <= '0;
            stk_rwb <= 1'b1;
            stk_en  <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            state   <= next_state;
            pc_load <= 1'b0;

            if (do_call) begin
                stk_din <= pc_in + DW'(1);
                stk_rwb <= 1'b0;
                stk_en  <= ~stk_en;
                depth   <= depth + 5'd1;
            end

            if (do_ret) begin
                stk_rwb <= 1'b1;
                stk_en  <= ~stk_en;
            end

            case (state)
                PUSH: begin
                    pc_out  <= target;
                    pc_load <= 1'b1;
                end
                CAPT: begin
                    pc_out  <= stk_dout;
                    pc_load <= 1'b1;
                    depth   <= depth - 5'd1;
                end
                // only entered when the trap option is built in
                ERR: begin
                    pc_out  <= TRAP_VEC;
                    pc_load <= 1'b1;
                end
                default: ;
            endcase

            // a new error on the same edge as clr_err keeps its flag set
            if (ovf_hit)
                ovf <= 1'b1;
            else if (clr_err)
                ovf <= 1'b0;

            if (unf_hit)
                unf <= 1'b1;
            else if (clr_err)
                unf <= 1'b0;
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_call_return_unit.sv
// Bench for call_return_unit: behavioural toggle-strobed stack, pc_out/push-data scoreboards, directed and random tasks.
module tb_call_return_unit;
  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] TRAP = 16'hFFF0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic call = 1'b0;
  logic ret = 1'b0;
  logic clr_err = 1'b0;
  logic [DW-1:0] pc_in = '0;
  logic [DW-1:0] target = '0;
  logic [DW-1:0] stk_dout = '0;
  logic [DW-1:0] stk_din;
  logic [DW-1:0] pc_out;
  logic stk_en, stk_rwb, pc_load, busy, ovf, unf;
  logic [4:0] depth;
  logic [2:0] state_dbg;

  call_return_unit #(.DEPTH(DEPTH), .DW(DW), .TRAP_VEC(TRAP)) dut (
    .clk(clk), .rst(rst), .call(call), .ret(ret), .pc_in(pc_in), .target(target),
    .stk_din(stk_din), .stk_dout(stk_dout), .stk_en(stk_en), .stk_rwb(stk_rwb),
    .pc_out(pc_out), .pc_load(pc_load), .busy(busy), .depth(depth), .ovf(ovf),
    .unf(unf), .clr_err(clr_err), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] din_q[$];
  logic [DW-1:0] ref_stk[$];
  int md = 0;
  logic exp_ovf = 1'b0;
  logic exp_unf = 1'b0;

  // behavioural stack plus output monitor, sampled on the falling edge
  logic [DW-1:0] mem[0:31];
  int sp = 0;
  int toggles = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst === 1'b1) begin
      sp = 0;
      prev_en = stk_en;
    end else begin
      if (stk_en !== prev_en) begin
        toggles++;
        if (stk_rwb === 1'b0) begin
          checks++;
          if (din_q.size() == 0)
            $display("FAIL push_data: unexpected push of %h", stk_din);
          else begin
            e = din_q.pop_front();
            if (stk_din !== e) $display("FAIL push_data: got %h expected %h", stk_din, e);
            else passed++;
          end
          if (sp < 32) mem[sp] = stk_din;
          sp++;
        end else begin
          if (sp > 0) sp--;
          stk_dout = (sp < 32) ? mem[sp] : '0;
        end
      end
      prev_en = stk_en;
      if (pc_load === 1'b1) begin
        checks++;
        if (exp_q.size() == 0)
          $display("FAIL pc_load: unexpected pulse with pc_out %h", pc_out);
        else begin
          e = exp_q.pop_front();
          if (pc_out !== e) $display("FAIL pc_out: got %h expected %h", pc_out, e);
          else passed++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk); #1;
      if (busy === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done) $display("FAIL wait_idle: busy %b still set after 8 cycles", busy);
    else passed++;
  endtask

  task automatic do_call(input logic [DW-1:0] pc, input logic [DW-1:0] tgt);
    @(posedge clk); #1;
    call = 1'b1; pc_in = pc; target = tgt;
    if (md < DEPTH) begin
      din_q.push_back(pc + 16'd1);
      exp_q.push_back(tgt);
      ref_stk.push_back(pc + 16'd1);
      md++;
    end else begin
      exp_ovf = 1'b1;
`ifdef STACK_TRAP_EN
      exp_q.push_back(TRAP);
`endif
    end
    @(posedge clk); #1;
    call = 1'b0;
    wait_idle();
  endtask

  task automatic do_ret();
    @(posedge clk); #1;
    ret = 1'b1;
    if (md > 0) begin
      exp_q.push_back(ref_stk.pop_back());
      md--;
    end else begin
      exp_unf = 1'b1;
`ifdef STACK_TRAP_EN
      exp_q.push_back(TRAP);
`endif
    end
    @(posedge clk); #1;
    ret = 1'b0;
    wait_idle();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; call = 1'b0; ret = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) $display("FAIL busy_in_reset: got %b expected 0", busy);
    else passed++;
    rst = 1'b0;
    md = 0; exp_ovf = 1'b0; exp_unf = 1'b0;
    ref_stk.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); #1;
    checks++;
    if ({state_dbg, busy, depth, pc_load, stk_rwb, stk_en, ovf, unf} !==
        {3'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_ctrl: state %0d busy %b depth %0d load %b rwb %b en %b ovf %b unf %b expected 0 0 0 0 1 0 0 0",
               state_dbg, busy, depth, pc_load, stk_rwb, stk_en, ovf, unf);
    else passed++;
    checks++;
    if ({pc_out, stk_din} !== 32'h0)
      $display("FAIL reset_data: pc_out %h stk_din %h expected 0000 0000", pc_out, stk_din);
    else passed++;
  endtask

  task automatic test_call();
    int t0;
    @(posedge clk); #1;
    t0 = toggles;
    call = 1'b1; pc_in = 16'h0100; target = 16'h0400;
    din_q.push_back(16'h0101); exp_q.push_back(16'h0400); ref_stk.push_back(16'h0101); md = 1;
    @(posedge clk); #1;
    call = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({busy, pc_load, stk_rwb, stk_din, depth} !== {1'b1, 1'b0, 1'b0, 16'h0101, 5'd1})
      $display("FAIL call_edge: busy %b load %b rwb %b din %h depth %0d expected 1 0 0 0101 1",
               busy, pc_load, stk_rwb, stk_din, depth);
    else passed++;
    checks++;
    if (toggles !== t0 + 1) $display("FAIL call_toggles: got %0d expected %0d", toggles - t0, 1);
    else passed++;
    @(negedge clk); #1;
    checks++;
    if ({pc_load, pc_out} !== {1'b1, 16'h0400})
      $display("FAIL call_load: load %b pc_out %h expected 1 0400", pc_load, pc_out);
    else passed++;
    @(negedge clk); #1;
    checks++;
    if ({pc_load, busy, depth} !== {1'b0, 1'b0, 5'd1})
      $display("FAIL call_done: load %b busy %b depth %0d expected 0 0 1", pc_load, busy, depth);
    else passed++;
  endtask

  task automatic test_return();
    int t0;
    @(posedge clk); #1;
    t0 = toggles;
    ret = 1'b1;
    exp_q.push_back(ref_stk.pop_back()); md = 0;
    @(posedge clk); #1;
    ret = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({busy, pc_load, stk_rwb} !== 3'b101 || toggles !== t0 + 1)
      $display("FAIL ret_edge: busy %b load %b rwb %b toggles %0d expected 1 0 1 1",
               busy, pc_load, stk_rwb, toggles - t0);
    else passed++;
    @(negedge clk); #1;
    checks++;
    if (pc_load !== 1'b0) $display("FAIL ret_early_load: got %b expected 0", pc_load);
    else passed++;
    @(negedge clk); #1;
    checks++;
    if ({pc_load, pc_out, depth} !== {1'b1, 16'h0101, 5'd0})
      $display("FAIL ret_load: load %b pc_out %h depth %0d expected 1 0101 0", pc_load, pc_out, depth);
    else passed++;
    @(negedge clk); #1;
    checks++;
    if ({pc_load, busy} !== 2'b00) $display("FAIL ret_done: load %b busy %b expected 0 0", pc_load, busy);
    else passed++;
  endtask

  task automatic test_overflow();
    int t0;
    t0 = toggles;
    for (int i = 0; i < DEPTH + 1; i++) begin
      do_call(16'($urandom()), 16'($urandom()));
      if (i == DEPTH - 1) begin
        checks++;
        if ({ovf, depth} !== {1'b0, 5'd16})
          $display("FAIL full_no_ovf: ovf %b depth %0d expected 0 16", ovf, depth);
        else passed++;
      end
    end
    checks++;
    if ({ovf, depth} !== {1'b1, 5'd16})
      $display("FAIL overflow: ovf %b depth %0d expected 1 16", ovf, depth);
    else passed++;
    checks++;
    if (toggles !== t0 + DEPTH) $display("FAIL ovf_toggles: got %0d expected %0d", toggles - t0, DEPTH);
    else passed++;
  endtask

  task automatic test_underflow();
    int t0;
    t0 = toggles;
    do_ret();
    checks++;
    if ({unf, depth} !== {1'b1, 5'd0} || toggles !== t0)
      $display("FAIL underflow: unf %b depth %0d toggles %0d expected 1 0 0", unf, depth, toggles - t0);
    else passed++;
    @(posedge clk); #1;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (unf !== 1'b0) $display("FAIL clr_err: unf %b expected 0", unf);
    else passed++;
    // clear and a fresh underflow on the same edge: the error wins
    @(posedge clk); #1;
    clr_err = 1'b1; ret = 1'b1;
`ifdef STACK_TRAP_EN
    exp_q.push_back(TRAP);
`endif
    @(posedge clk); #1;
    clr_err = 1'b0; ret = 1'b0;
    wait_idle();
    checks++;
    if (unf !== 1'b1) $display("FAIL clr_vs_err: unf %b expected 1", unf);
    else passed++;
    @(posedge clk); #1;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    exp_unf = 1'b0;
  endtask

  task automatic test_simultaneous();
    int t0;
    @(posedge clk); #1;
    t0 = toggles;
    call = 1'b1; ret = 1'b1; pc_in = 16'h1234; target = 16'h2000;
    din_q.push_back(16'h1235); exp_q.push_back(16'h2000); ref_stk.push_back(16'h1235); md = 1;
    @(posedge clk); #1;
    call = 1'b0;
    @(posedge clk); #1;
    ret = 1'b0;
    wait_idle();
    checks++;
    if ({depth, stk_rwb} !== {5'd1, 1'b0} || toggles !== t0 + 1)
      $display("FAIL simultaneous: depth %0d rwb %b toggles %0d expected 1 0 1", depth, stk_rwb, toggles - t0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic en_snap;
    @(posedge clk); #1;
    ret = 1'b1;
    @(posedge clk); #1;
    ret = 1'b0; rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (state_dbg !== 3'd3) $display("FAIL pop_state: got %0d expected 3", state_dbg);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    md = 0; ref_stk.delete(); exp_ovf = 1'b0; exp_unf = 1'b0;
    en_snap = stk_en;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if ({stk_en, depth, busy, pc_load} !== {en_snap, 5'd0, 1'b0, 1'b0})
      $display("FAIL reset_mid: en %b depth %0d busy %b load %b expected %b 0 0 0",
               stk_en, depth, busy, pc_load, en_snap);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_call(16'hFFFF, 16'h0010);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) do_call(16'($urandom()), 16'($urandom()));
      else do_ret();
      checks++;
      if ({depth, ovf, unf} !== {5'(md), exp_ovf, exp_unf})
        $display("FAIL b2b_%0d: depth %0d ovf %b unf %b expected %0d %b %b",
                 i, depth, ovf, unf, md, exp_ovf, exp_unf);
      else passed++;
    end
    while (md > 0) do_ret();
    do_ret();
    checks++;
    if ({depth, unf} !== {5'd0, 1'b1}) $display("FAIL b2b_drain: depth %0d unf %b expected 0 1", depth, unf);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_call();
    test_return();
    test_overflow();
    test_reset();
    test_underflow();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || din_q.size() != 0)
      $display("FAIL leftover: %0d pc_out and %0d push entries never seen", exp_q.size(), din_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
